// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Shares one multi-cycle shift-add multiplier between two requesters. A request
// seen in IDLE is granted, the winner's operands and identity are latched, the
// multiplier receives a single start opcode, and after MUL_LAT cycles the
// product is captured and a one-cycle done pulse goes back to the owner.
//
// Arbitration when both requesters are high:
//   default                         : round-robin on the previous owner
//   MUL_ARBITER_FIXED_PRIORITY_EN   : requester 0 always wins
//
// Parameters
//   MUL_LAT    cycles from the start cycle's rising edge until mul_result is stable
//   SIG_MULTU  multiplier start opcode
//   SIG_IDLE   multiplier no-op opcode
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   req0, req1   requests; held until the matching done pulse
//   a0, b0       requester 0 operands (unsigned)
//   a1, b1       requester 1 operands (unsigned)
//   done0, done1 one-cycle completion pulse to the owner
//   result       product of the last completed operation
//   busy         high whenever the arbiter is not in IDLE
//   mul_signal   opcode to the shared multiplier
//   mul_a, mul_b operands to the shared multiplier
//   mul_result   product returned by the multiplier
// -----------------------------------------------------------------------------
module mul_arbiter #(
  parameter int unsigned MUL_LAT   = 33,
  parameter logic [5:0]  SIG_MULTU = 6'b011001,
  parameter logic [5:0]  SIG_IDLE  = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] result,
  output logic        busy,
  output logic [5:0]  mul_signal,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result
);

  // Counter only has to reach MUL_LAT-1; guard the degenerate MUL_LAT=1 case.
  localparam int unsigned     CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             owner_q;   // 0: requester 0, 1: requester 1
  logic             any_req;
  logic             grant;     // requester chosen in IDLE
  logic             cnt_last;

  assign any_req  = req0 | req1;
  assign cnt_last = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MUL_ARBITER_FIXED_PRIORITY_EN
  // Requester 0 wins every tie; the previous owner is irrelevant.
  always_comb begin
    grant = ~req0 & req1;
  end
`else
  logic last_owner_q;

  // On a tie the requester that did not own the previous operation wins.
  always_comb begin
    grant = req1;
    if (req0 && req1) grant = ~last_owner_q;
  end

  // Starts at 1 so the first tie after reset goes to requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= 1'b1;
    end else if (state_q == DONE) begin
      last_owner_q <= owner_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    mul_signal = SIG_IDLE;
    done0      = 1'b0;
    done1      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        // The only cycle the start opcode is driven, so the multiplier is never
        // restarted while an operation is in flight.
        mul_signal = SIG_MULTU;
        state_d    = WAIT;
      end
      WAIT: begin
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand latch, wait counter, result capture
  // ---------------------------------------------------------------------------
  // Operands are latched once at acceptance, so later changes on a*/b*/req*
  // cannot disturb the operation in flight. In IDLE without a request the
  // multiplier operands simply keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      cnt_q   <= '0;
      result  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant;
            mul_a   <= grant ? a1 : a0;
            mul_b   <= grant ? b1 : b0;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (cnt_last) begin
            // Counter stops at its terminal value instead of wrapping.
            result <= mul_result;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
